// File: rtl/temp_sample_proc.sv
// Temperature sample processor: assembles two-byte TMP102 reads into 12-bit
// signed samples, keeps a power-of-two moving average, a hysteresis alert,
// a sample counter, and flags out-of-order or stalled frames.
// Latency: sample outputs update 1 cycle after the LSB strobe. No back-pressure.
module temp_sample_proc #(
  parameter int AVG_LOG2    = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        FAB_CCC_GL0,
  input  logic        FAB_RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        RX_FIRST,
  input  logic        RX_ABORT,
  input  logic [11:0] T_HIGH,
  input  logic [11:0] T_LOW,
  output logic [11:0] TEMP_RAW,
  output logic [11:0] TEMP_AVG,
  output logic        SAMPLE_VALID,
  output logic        AVG_VALID,
  output logic        ALERT,
  output logic        FRAME_ERR,
  output logic [15:0] SAMPLE_CNT
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = 12 + AVG_LOG2;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {WAIT_MSB, WAIT_LSB} state_t;

  state_t              state, state_nxt;
  logic [7:0]          msb;
  logic [TW-1:0]       tmo_cnt;
  logic                load_msb, commit, err_set, tmo_inc;
  logic [11:0]         sample;
  logic [11:0]         oldest;
  logic [11:0]         hist [WIN];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill_cnt;
  logic signed [SW-1:0] sum, sum_nxt;

  // Low nibble of the LSB byte carries no temperature information.
  assign sample  = {msb, RX_DATA[7:4]};
  assign oldest  = hist[wr_ptr];
  assign sum_nxt = sum + $signed({{AVG_LOG2{sample[11]}}, sample})
                       - $signed({{AVG_LOG2{oldest[11]}}, oldest});

  // Frame FSM: next state and control strobes; abort overrides everything.
  always_comb begin
    state_nxt = state;
    load_msb  = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    tmo_inc   = 1'b0;
    if (RX_ABORT) begin
      state_nxt = WAIT_MSB;
    end else begin
      case (state)
        WAIT_MSB: begin
          if (RX_VALID) begin
            if (RX_FIRST) begin
              load_msb  = 1'b1;
              state_nxt = WAIT_LSB;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        WAIT_LSB: begin
          if (RX_VALID) begin
            if (RX_FIRST) begin
              // Restarted frame: report it, but keep the newer MSB.
              err_set  = 1'b1;
              load_msb = 1'b1;
            end else begin
              commit    = 1'b1;
              state_nxt = WAIT_MSB;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_set   = 1'b1;
            state_nxt = WAIT_MSB;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        default: state_nxt = WAIT_MSB;
      endcase
    end
  end

  // Frame state, latched MSB and stall timer (cleared whenever not counting).
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      state     <= WAIT_MSB;
      msb       <= '0;
      tmo_cnt   <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      FRAME_ERR <= err_set;
      tmo_cnt   <= tmo_inc ? tmo_cnt + 1'b1 : '0;
      if (RX_ABORT)      msb <= '0;
      else if (load_msb) msb <= RX_DATA;
    end
  end

  // History ring: the oldest entry is replaced by each committed sample.
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      for (int i = 0; i < WIN; i++) hist[i] <= '0;
      wr_ptr <= '0;
    end else if (commit) begin
      hist[wr_ptr] <= sample;
      wr_ptr       <= wr_ptr + 1'b1;
    end
  end

  // Sample outputs, running average, fill tracking, counter and alert.
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      TEMP_RAW     <= '0;
      TEMP_AVG     <= '0;
      SAMPLE_VALID <= 1'b0;
      AVG_VALID    <= 1'b0;
      ALERT        <= 1'b0;
      SAMPLE_CNT   <= '0;
      sum          <= '0;
      fill_cnt     <= '0;
    end else begin
      SAMPLE_VALID <= commit;
      if (commit) begin
        TEMP_RAW   <= sample;
        // Top 12 bits of the sum are the arithmetic shift by AVG_LOG2.
        TEMP_AVG   <= sum_nxt[SW-1:AVG_LOG2];
        sum        <= sum_nxt;
        SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
        if (fill_cnt != (AVG_LOG2 + 1)'(WIN)) fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == (AVG_LOG2 + 1)'(WIN - 1)) AVG_VALID <= 1'b1;
        if ($signed(sample) > $signed(T_HIGH))     ALERT <= 1'b1;
        else if ($signed(sample) < $signed(T_LOW)) ALERT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_proc.sv
// Randomized + directed bench for temp_sample_proc with a queue scoreboard.
// Reference model works on whole samples: last-W history list and integer math.
module tb_temp_sample_proc;

  localparam int L = 2;
  localparam int W = 1 << L;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_first, rx_abort;
  logic [11:0] t_high, t_low;
  logic [11:0] temp_raw, temp_avg;
  logic        sample_valid, avg_valid, alert, frame_err;
  logic [15:0] sample_cnt;

  always #5 clk = ~clk;

  temp_sample_proc #(.AVG_LOG2(L), .TIMEOUT_CYC(16)) dut (
    .FAB_CCC_GL0(clk), .FAB_RESET(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RX_FIRST(rx_first), .RX_ABORT(rx_abort), .T_HIGH(t_high), .T_LOW(t_low),
    .TEMP_RAW(temp_raw), .TEMP_AVG(temp_avg), .SAMPLE_VALID(sample_valid),
    .AVG_VALID(avg_valid), .ALERT(alert), .FRAME_ERR(frame_err),
    .SAMPLE_CNT(sample_cnt)
  );

  typedef struct {
    logic [11:0] raw;
    logic [11:0] avg;
    logic        av;
    logic        al;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          hist[$];
  int          nsamp, m_cnt, exp_err, obs_err;
  bit          m_alert, have_msb;
  logic [7:0]  m_msb;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every SAMPLE_VALID pops one expected sample; FRAME_ERR pulses are counted.
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("temp_raw", int'(temp_raw), int'(mon_e.raw));
          check("temp_avg", int'(temp_avg), int'(mon_e.avg));
          check("avg_valid", int'(avg_valid), int'(mon_e.av));
          check("alert", int'(alert), int'(mon_e.al));
          check("sample_cnt", int'(sample_cnt), int'(mon_e.cnt));
        end
      end
      if (frame_err) obs_err++;
    end
  end

  task automatic model_reset();
    hist.delete();
    nsamp = 0; m_cnt = 0; m_alert = 0; have_msb = 0;
  endtask

  task automatic model_commit(input logic [11:0] s);
    int   sv, sum;
    exp_t e;
    sv = int'($signed(s));
    hist.push_back(sv);
    if (hist.size() > W) void'(hist.pop_front());
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    if (sv > int'($signed(t_high)))     m_alert = 1;
    else if (sv < int'($signed(t_low))) m_alert = 0;
    m_cnt = (m_cnt + 1) % 65536;
    nsamp++;
    e.raw = s;
    e.avg = 12'(sum >>> L);
    e.av  = (nsamp >= W);
    e.al  = m_alert;
    e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit f);
    if (f) begin
      if (have_msb) exp_err++;
      have_msb = 1; m_msb = d;
    end else if (have_msb) begin
      model_commit({m_msb, d[7:4]});
      have_msb = 0;
    end else begin
      exp_err++;
    end
    rx_data = d; rx_first = f; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_first = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic abort(input bit with_byte, input logic [7:0] d, input bit f);
    have_msb = 0;
    rx_abort = 1'b1; rx_valid = with_byte; rx_first = f; rx_data = d;
    @(posedge clk); #1;
    rx_abort = 1'b0; rx_valid = 1'b0; rx_first = 1'b0;
  endtask

  task automatic frame(input logic [11:0] v);
    logic [7:0] lsb;
    lsb = {v[3:0], 4'($urandom)};
    send(v[11:4], 1'b1);
    idle($urandom_range(0, 3));
    send(lsb, 1'b0);
  endtask

  task automatic check_outputs_zero();
    check("rst_temp_raw", int'(temp_raw), 0);
    check("rst_temp_avg", int'(temp_avg), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_alert", int'(alert), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_sample_cnt", int'(sample_cnt), 0);
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs_zero();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r, lo, hi;
    logic [11:0] avg_tab [5];
    logic        alert_tab [4];
    logic [11:0] alert_smp [4];
    avg_tab   = '{12'h004, 12'h00C, 12'h018, 12'h028, 12'h038};
    alert_smp = '{12'h330, 12'h300, 12'h2C0, 12'h320};
    alert_tab = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; rx_data = '0; rx_valid = 0; rx_first = 0; rx_abort = 0;
    t_high = 12'h7FF; t_low = 12'h800;
    exp_err = 0; obs_err = 0;
    model_reset();
    #2;
    check_outputs_zero();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Positive sample with latency check, then negative sample.
    send(8'h19, 1'b1);
    send(8'h00, 1'b0);
    check("pos_valid_pulse", int'(sample_valid), 1);
    check("pos_raw", int'(temp_raw), 'h190);
    idle(1);
    check("pos_valid_drop", int'(sample_valid), 0);
    send(8'hE7, 1'b1);
    send(8'h0F, 1'b0);
    check("neg_raw", int'(temp_raw), 'hE70);

    // Averaging ramp from a cleared window.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frame(12'((i + 1) * 16));
      check("avg_table", int'(temp_avg), int'(avg_tab[i]));
      check("avg_valid_table", int'(avg_valid), (i >= 3) ? 1 : 0);
    end

    // Hysteresis.
    t_high = 12'h320; t_low = 12'h2D0;
    for (int i = 0; i < 4; i++) begin
      frame(alert_smp[i]);
      check("alert_table", int'(alert), int'(alert_tab[i]));
    end

    // Framing errors.
    send(8'h12, 1'b0);
    check("lone_lsb_err", int'(frame_err), 1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    check("double_first_err", int'(frame_err), 1);
    send(8'h30, 1'b0);
    check("double_first_raw", int'(temp_raw), 'h223);
    send(8'h44, 1'b1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", lat, 16);
    exp_err++; have_msb = 0;
    send(8'h55, 1'b1);
    idle(2);
    abort(1'b0, 8'h00, 1'b0);
    idle(3);
    check("abort_no_err", int'(frame_err), 0);

    // Reset in the middle of a frame: the following LSB is orphaned.
    send(8'h40, 1'b1);
    idle(1);
    do_reset();
    send(8'h50, 1'b0);
    check("reset_orphan_err", int'(frame_err), 1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 4) == 0) begin
        lo = int'($urandom_range(0, 4095)) - 2048;
        hi = lo + int'($urandom_range(0, 2047 - lo));
        t_low = 12'(lo); t_high = 12'(hi);
      end
      if (r < 65)      frame(12'($urandom));
      else if (r < 73) send(8'($urandom), 1'b0);
      else if (r < 81) send(8'($urandom), 1'b1);
      else if (r < 90) abort(1'b0, 8'h00, 1'b0);
      else             abort(1'b1, 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end
    if (have_msb) abort(1'b0, 8'h00, 1'b0);

    idle(5);
    check("frame_err_count", obs_err, exp_err);
    check("pending_samples", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
